program_loader: RTL and testbench

- Writer side of the instruction memory. The CPU core only reads that memory; this block fills it before the core runs.
- Accepts a byte stream over a valid/ready handshake and assembles bytes little-endian into 32-bit words.
- Writes each word to consecutive word addresses starting at 0.
- Holds the CPU core in reset until the requested word count has been written, then releases it.

---
 rtl/program_loader_if.sv | 33 +++
 rtl/program_loader.sv | 134 +++++++++++++
 tb/tb_program_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Bundles the loader's control, byte-stream and instruction-memory-write
// signals. The loader itself uses the slave modport; whoever drives the byte
// stream and observes status uses the master modport.
interface program_loader_if #(
  parameter int ADDR_W = 8
);
  // control from the system
  logic              start;
  logic [ADDR_W:0]   word_count;
  // byte stream (valid/ready)
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  // instruction memory write port
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  // status and core reset
  logic              cpu_rst;
  logic              busy;
  logic              done;
  logic              error;

  modport slave (
    input  start, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error
  );

  modport master (
    output start, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rst, busy, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Fills the instruction memory from a byte stream before the CPU core runs.
// Bytes are packed little-endian into 32-bit words, written to word addresses
// 0,1,2,... and the core is held in reset until the requested number of words
// has been written. A stalled stream (TIMEOUT idle cycles) aborts the load.
module program_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  // Largest loadable count: the whole memory, 2^ADDR_W words.
  localparam logic [ADDR_W:0]   MAX_CNT    = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   ONE_CNT    = 1;
  localparam logic [ADDR_W-1:0] ONE_ADDR   = 1;
  localparam logic [TW-1:0]     ONE_TIMER  = 1;
  localparam logic [TW-1:0]     TIMER_LAST = TIMEOUT - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        idx_q, idx_d;
  logic [TW-1:0]     timer_q, timer_d;

  logic [ADDR_W:0]   cnt_clamped;
  logic              last_word;

  // Requested word count, limited so the address counter never has to wrap.
  assign cnt_clamped = (bus.word_count > MAX_CNT) ? MAX_CNT : bus.word_count;
  // The word currently being written is the final one of this load.
  assign last_word   = ({1'b0, addr_q} == (cnt_q - ONE_CNT));

  // Next-state and datapath updates for the load sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    idx_d   = idx_q;
    timer_d = timer_q;

    case (state_q)
      // IDLE, DONE and ERR all accept a new load; rst has priority via the
      // flop block, so a coincident start is simply lost.
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          cnt_d   = cnt_clamped;
          addr_d  = '0;
          idx_d   = '0;
          timer_d = '0;
          state_d = (cnt_clamped == '0) ? S_DONE : S_LOAD;
        end
      end

      S_LOAD: begin
        // byte_ready is high throughout LOAD, so valid alone is a transfer.
        if (bus.byte_valid) begin
          wdata_d[8*idx_q +: 8] = bus.byte_data;
          idx_d   = idx_q + 2'd1;
          timer_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_WRITE;
          end
        end else if (timer_q == TIMER_LAST) begin
          // Partial word is abandoned; earlier words stay in memory.
          state_d = S_ERR;
        end else begin
          timer_d = timer_q + ONE_TIMER;
        end
      end

      S_WRITE: begin
        // Single write cycle; the address only advances if more words follow,
        // so it rests on the last written address when the load completes.
        if (last_word) begin
          state_d = S_DONE;
        end else begin
          addr_d  = addr_q + ONE_ADDR;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_LOAD;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Status and handshake outputs are pure decodes of the state register, so
  // there is no path from byte_valid to byte_ready.
  assign bus.byte_ready = (state_q == S_LOAD);
  assign bus.im_we      = (state_q == S_WRITE);
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = wdata_q;
  assign bus.busy       = (state_q == S_LOAD) || (state_q == S_WRITE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.error      = (state_q == S_ERR);
  assign bus.cpu_rst    = (state_q != S_DONE);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: every word sent is pushed as an
// expected {addr, data} write; a monitor collects the real writes and each
// scenario task drains and compares the two queues.
module tb_program_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 1024;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  wr_t exp_q[$];
  wr_t obs_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  program_loader_if #(.ADDR_W(ADDR_W)) bus ();

  program_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Monitor: record each memory write, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) obs_q.push_back({bus.im_addr, bus.im_wdata});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int wc);
    bus.word_count = (ADDR_W + 1)'(wc);
    bus.start      = 1'b1;
    tick();
    bus.start      = 1'b0;
  endtask

  // Offer one byte until the loader takes it (bounded), then idle 'gap' cycles.
  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    ok = 1'b0;
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.byte_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.byte_valid = 1'b0;
    repeat (gap) tick();
  endtask

  // Send a word LSB first and expect it written at 'addr'.
  task automatic send_word(input int addr, input logic [31:0] w, input int gap, output bit ok);
    bit b_ok;
    ok = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8], gap, b_ok);
      ok &= b_ok;
    end
    exp_q.push_back({addr[ADDR_W-1:0], w});
  endtask

  task automatic test_reset();
    logic [43:0] got;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.word_count = 9'd2;
    bus.byte_valid = 1'b1;
    bus.byte_data = 8'hA5;
    repeat (3) tick();
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    got = {bus.byte_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_rst, bus.busy, bus.done, bus.error};
    n_cmp++;
    if (got !== {2'b00, 8'h00, 32'h0, 4'b1000}) begin
      n_bad++;
      $display("FAIL reset_values: got %h want %h", got, {2'b00, 8'h00, 32'h0, 4'b1000});
    end
    // valid in IDLE must be ignored
    repeat (3) tick();
    n_cmp++;
    if ({bus.byte_ready, bus.busy, bus.cpu_rst} !== 3'b001 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL idle_ignores_valid: ready/busy/cpu_rst=%b writes=%0d want 001 and 0",
               {bus.byte_ready, bus.busy, bus.cpu_rst}, obs_q.size());
    end
    bus.byte_valid = 1'b0;
    $display("test_reset: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_load(input string name, input int gap);
    bit ok, all_ok;
    int c0, n;
    wr_t e, o;
    all_ok = 1'b1;
    pulse_start(2);
    c0 = cyc;
    n_cmp++;
    if ({bus.byte_ready, bus.busy, bus.cpu_rst, bus.done} !== 4'b1110) begin
      n_bad++;
      $display("FAIL %s_load_entry: ready/busy/cpu_rst/done=%b want 1110", name,
               {bus.byte_ready, bus.busy, bus.cpu_rst, bus.done});
    end
    send_word(0, 32'h00500013, gap, ok); all_ok &= ok;
    send_word(1, 32'h00100093, gap, ok); all_ok &= ok;
    n_cmp++;
    if (!all_ok) begin
      n_bad++;
      $display("FAIL %s_bytes_accepted: got stalled stream want all bytes taken", name);
    end
    n = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        n = cyc - c0;
        break;
      end
    end
    n_cmp++;
    if (n < 0 || bus.cpu_rst !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_done: done_after=%0d cpu_rst=%b want done with cpu_rst 0", name, n, bus.cpu_rst);
    end
    if (gap == 0) begin
      n_cmp++;
      if (n != 10) begin
        n_bad++;
        $display("FAIL %s_latency: got %0d cycles want 10", name, n);
      end
    end
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL %s_write_count: got %0d want %0d", name, obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL %s_write: got addr %0d data %h want addr %0d data %h", name, o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_%s: done after %0d cycles, compared=%0d mismatched=%0d", name, n, n_cmp, n_bad);
  endtask

  task automatic test_zero();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_pre_done: got %b want 0", bus.done);
    end
    pulse_start(0);
    n_cmp++;
    if ({bus.done, bus.cpu_rst, bus.busy} !== 3'b100) begin
      n_bad++;
      $display("FAIL zero_done: done/cpu_rst/busy=%b want 100", {bus.done, bus.cpu_rst, bus.busy});
    end
    repeat (3) tick();
    n_cmp++;
    if (obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL zero_no_write: got %0d writes want 0", obs_q.size());
    end
    obs_q.delete();
    $display("test_zero: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  task automatic test_timeout();
    bit ok, all_ok;
    int ca, n;
    wr_t e, o;
    all_ok = 1'b1;
    pulse_start(1);
    send_byte(8'h11, 0, ok); all_ok &= ok;
    send_byte(8'h22, 0, ok); all_ok &= ok;
    ca = cyc;
    n = -1;
    for (int i = 0; i < TIMEOUT + 20; i++) begin
      @(negedge clk);
      if (bus.error === 1'b1) begin
        n = cyc - ca;
        break;
      end
    end
    n_cmp++;
    if (n != TIMEOUT || !all_ok) begin
      n_bad++;
      $display("FAIL timeout_latency: error after %0d idle cycles (bytes ok=%b) want %0d", n, all_ok, TIMEOUT);
    end
    n_cmp++;
    if ({bus.error, bus.cpu_rst, bus.done, bus.busy} !== 4'b1100 || obs_q.size() != 0) begin
      n_bad++;
      $display("FAIL timeout_state: error/cpu_rst/done/busy=%b writes=%0d want 1100 and 0",
               {bus.error, bus.cpu_rst, bus.done, bus.busy}, obs_q.size());
    end
    tick();
    pulse_start(1);
    n_cmp++;
    if ({bus.error, bus.cpu_rst, bus.busy} !== 3'b011) begin
      n_bad++;
      $display("FAIL timeout_restart: error/cpu_rst/busy=%b want 011", {bus.error, bus.cpu_rst, bus.busy});
    end
    send_word(0, 32'hDEADBEEF, 0, ok);
    repeat (3) tick();
    n_cmp++;
    if ({bus.done, bus.error, bus.cpu_rst} !== 3'b100 || !ok) begin
      n_bad++;
      $display("FAIL timeout_recover: done/error/cpu_rst=%b want 100", {bus.done, bus.error, bus.cpu_rst});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL timeout_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL timeout_write: got addr %0d data %h want addr %0d data %h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_timeout: error after %0d cycles, compared=%0d mismatched=%0d", n, n_cmp, n_bad);
  endtask

  task automatic test_clamp();
    bit ok, all_ok;
    logic [7:0] w8;
    int n_wr;
    wr_t e, o;
    all_ok = 1'b1;
    pulse_start(300);
    for (int w = 0; w < 256; w++) begin
      if (w == 10 || w == 100) begin
        // start while in WRITE then in LOAD, with a small count on the bus
        bus.word_count = 9'd1;
        bus.start = 1'b1;
        repeat (2) tick();
        bus.start = 1'b0;
      end
      w8 = 8'(w);
      send_word(w, {w8, ~w8, w8 ^ 8'h5A, w8 + 8'd3}, 0, ok);
      all_ok &= ok;
    end
    repeat (4) tick();
    n_cmp++;
    if ({bus.done, bus.im_addr} !== {1'b1, 8'hFF} || !all_ok) begin
      n_bad++;
      $display("FAIL clamp_done: done=%b im_addr=%0d bytes_ok=%b want 1, 255, 1", bus.done, bus.im_addr, all_ok);
    end
    n_wr = obs_q.size();
    n_cmp++;
    if (n_wr != 256) begin
      n_bad++;
      $display("FAIL clamp_write_count: got %0d want 256", n_wr);
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL clamp_write: got addr %0d data %h want addr %0d data %h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_clamp: %0d writes, compared=%0d mismatched=%0d", n_wr, n_cmp, n_bad);
  endtask

  task automatic test_reset_abort();
    bit ok, all_ok;
    logic [43:0] got;
    wr_t e, o;
    all_ok = 1'b1;
    pulse_start(2);
    send_word(0, 32'hCAFE0001, 0, ok); all_ok &= ok;
    send_byte(8'h77, 0, ok); all_ok &= ok;
    send_byte(8'h66, 0, ok); all_ok &= ok;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    got = {bus.byte_ready, bus.im_we, bus.im_addr, bus.im_wdata, bus.cpu_rst, bus.busy, bus.done, bus.error};
    n_cmp++;
    if (got !== {2'b00, 8'h00, 32'h0, 4'b1000} || !all_ok) begin
      n_bad++;
      $display("FAIL abort_reset_values: got %h want %h", got, {2'b00, 8'h00, 32'h0, 4'b1000});
    end
    tick();
    pulse_start(2);
    send_word(0, 32'h12345678, 0, ok); all_ok &= ok;
    send_word(1, 32'h9ABCDEF0, 0, ok); all_ok &= ok;
    repeat (3) tick();
    n_cmp++;
    if ({bus.done, bus.cpu_rst} !== 2'b10 || !all_ok) begin
      n_bad++;
      $display("FAIL abort_reload_done: done/cpu_rst=%b want 10", {bus.done, bus.cpu_rst});
    end
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_bad++;
      $display("FAIL abort_write_count: got %0d want %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_cmp++;
      if (o !== e) begin
        n_bad++;
        $display("FAIL abort_write: got addr %0d data %h want addr %0d data %h", o.addr, o.data, e.addr, e.data);
      end
    end
    exp_q.delete();
    obs_q.delete();
    $display("test_reset_abort: compared=%0d mismatched=%0d", n_cmp, n_bad);
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data = '0;
    test_reset();
    test_load("basic", 0);
    test_load("gaps", 1);
    test_zero();
    test_timeout();
    test_clamp();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
